fifo_access_arbiter: RTL and testbench
======================================

Name: fifo_access_arbiter

Overview:
- Round-robin arbiter and flow controller that shares one push port of the 8-entry, 8-bit FIFO among NUM_REQ requesters and gates the consumer's pop.
- Keeps its own occupancy count and drives registered full/empty flags, because the FIFO ties its own flags to 0.
- Provides a drain sequence that empties the FIFO on command, for use before re-arming the scoreboard.
- Sits between the traffic sources and the FIFO/MagicPacketTracker pair; its fifo_push/fifo_pop outputs feed both.

Parameters:
NUM_REQ, 4, number of push requesters (2..8)
DATA_WIDTH, 8, FIFO word width
DEPTH, 8, FIFO entry count (power of two)
CNT_WIDTH, 4, occupancy counter width, equal to log2(DEPTH)+1

Ports:
CLK  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-requester push request
req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as push
pop_req  input  1  consumer pop request
pop_ack  output  1  pop accepted this cycle, combinational
drain  input  1  start-drain command, sampled in RUN only
drain_done  output  1  one-cycle registered pulse when drain completes
fifo_push  output  1  to FIFO push; equals |gnt
fifo_pop  output  1  to FIFO pop; equals pop_ack or drain pop
fifo_data_in  output  DATA_WIDTH  data of the granted requester; 0 when no grant
count  output  CNT_WIDTH  registered occupancy, 0..DEPTH
full  output  1  registered, count==DEPTH
empty  output  1  registered, count==0

Behaviour:
- Single clock CLK. All state resets synchronously on rst=1 at the rising edge.
- Reset values: count=0, empty=1, full=0, drain_done=0, state=RUN, last_gnt=NUM_REQ-1 (so requester 0 wins first).
- rst has priority over every other input. Asserting rst mid-drain returns to RUN with no drain_done pulse.
- Combinational outputs during a cycle with rst=1 are don't-care, but fifo_push and fifo_pop must be 0.
- FSM states:
  - RUN: arbitration active. drain=1 moves to DRAIN on the next edge. A push may still be granted in the same cycle drain is sampled.
  - DRAIN: gnt=0, pop_ack=0, and fifo_pop=1 whenever count>0.
  - DRAIN to RUN: happens on the edge where count becomes 0. drain_done=1 for exactly the first RUN cycle.
  - DRAIN entered with count=0 lasts one cycle, then pulses drain_done.
  - drain asserted while already in DRAIN is ignored.
- Arbitration, in RUN only:
  - Push is eligible only when full=0. There is no bypass when full, even if a pop occurs in the same cycle.
  - Search starts at (last_gnt+1) mod NUM_REQ and grants the first requester with req=1.
  - last_gnt updates to the granted index only on a grant.
  - At most one grant per cycle. Ungranted requesters hold req; there is no queueing inside the block.
- Pop:
  - pop_ack = pop_req & ~empty & (state==RUN).
  - There is no pass-through on empty: a push and pop_req in the same cycle with count=0 gives pop_ack=0.
- Occupancy:
  - count_next = count + fifo_push - fifo_pop.
  - Simultaneous push and pop leaves count unchanged.
  - count never exceeds DEPTH and never goes below 0; both are guaranteed by the gating above.
- full and empty are derived from count_next and registered, so they are exact on the cycle count changes.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined:
  - Adds output reject_cnt (16 bits, registered, reset 0).
  - Increments by 1 each cycle in which any req=1 but no grant is issued (full, DRAIN, or losing arbitration).
  - Saturates at 16'hFFFF.
  - Clears on rst or on a drain_done pulse.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all inputs 0 -> count=0, empty=1, full=0, gnt=0, fifo_push=0, drain_done=0.
- Round-robin: req=4'b1111 held for 8 cycles with pop_req=0 -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; count reaches 8 and full=1; the 9th cycle gives gnt=0.
- Full plus pop: count=8, req=4'b0001, pop_req=1 -> pop_ack=1, gnt=0, count=7; next cycle gnt=0001 with pop_req=1, count stays 7.
- Empty plus simultaneous push/pop: count=0, req=4'b0100 with data 8'hA5, pop_req=1 -> gnt=0100, fifo_data_in=8'hA5, pop_ack=0, count=1; next cycle pop_ack=1.
- Drain: count=5, drain=1 with req=4'b0011 held -> exactly 5 cycles of fifo_pop=1 with gnt=0; count goes 5 to 0; drain_done=1 for one cycle; arbitration resumes the following cycle. With FIFO_ARB_STATS_EN, reject_cnt returns to 0.
- Reset mid-drain: count=6, drain, then rst on the 3rd drain cycle -> next cycle count=0, state RUN, drain_done stays 0, and requester 0 gets first priority.

Source files
------------

// File: rtl/fifo_access_arbiter.sv
// Round-robin push arbiter and pop gate for a shared FIFO, with its own occupancy
// tracking and a drain sequence. Optional reject counter: define FIFO_ARB_STATS_EN.
module fifo_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          pop_req,
  output logic                          pop_ack,
  input  logic                          drain,
  output logic                          drain_done,
  output logic                          fifo_push,
  output logic                          fifo_pop,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [CNT_WIDTH-1:0]          count,
  output logic                          full,
  output logic                          empty,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0]                   reject_cnt,
`endif
  output logic                          state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_q, empty_q;
  logic                 drain_done_q, drain_done_d;
  logic                 drain_pop;
  logic                 found;

  function automatic int rr_idx(input int base, input int k);
    return (base + k) % NUM_REQ;
  endfunction

  // Handshakes: req/gnt and pop_req/pop_ack are level requests; a request is
  // taken in exactly the cycle its grant/ack is high, and otherwise must be held.
  always_comb begin
    gnt        = '0;
    found      = 1'b0;
    last_gnt_d = last_gnt_q;
    if (!rst && state_q == S_RUN && !full_q) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && req[rr_idx(int'(last_gnt_q), k)]) begin
          found                                  = 1'b1;
          gnt[rr_idx(int'(last_gnt_q), k)]       = 1'b1;
          last_gnt_d                             = IDX_W'(rr_idx(int'(last_gnt_q), k));
        end
      end
    end
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign pop_ack   = pop_req & ~empty_q & (state_q == S_RUN) & ~rst;
  assign drain_pop = (state_q == S_DRAIN) & (count_q != '0) & ~rst;
  assign fifo_push = |gnt;
  assign fifo_pop  = pop_ack | drain_pop;
  assign count_d   = count_q + CNT_WIDTH'(fifo_push) - CNT_WIDTH'(fifo_pop);

  // DRAIN exits on the edge that empties the FIFO (immediately if already empty).
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      S_RUN:   if (drain) state_d = S_DRAIN;
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d      = S_RUN;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_RUN;
      last_gnt_q   <= IDX_W'(NUM_REQ - 1);
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      count_q      <= count_d;
      full_q       <= (count_d == CNT_WIDTH'(DEPTH));
      empty_q      <= (count_d == '0);
      drain_done_q <= drain_done_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] reject_cnt_q;

  always_ff @(posedge CLK) begin
    if (rst || drain_done_d) begin
      reject_cnt_q <= '0;
    end else if (|req && !fifo_push && reject_cnt_q != 16'hFFFF) begin
      reject_cnt_q <= reject_cnt_q + 16'd1;
    end
  end

  assign reject_cnt = reject_cnt_q;
`endif

  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign drain_done = drain_done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter: the driver queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_fifo_access_arbiter;

  localparam int W = 23;
  localparam logic [W-1:0] M_ALL  = '1;
  localparam logic [W-1:0] M_RST1 = 23'h000060;
  localparam logic [W-1:0] M_RST2 = 23'h7F8060;

  logic        CLK = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        pop_req, pop_ack, drain, drain_done;
  logic        fifo_push, fifo_pop;
  logic [7:0]  fifo_data_in;
  logic [3:0]  count;
  logic        full, empty, state_o;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] reject_cnt;
`endif

  fifo_access_arbiter dut (
    .CLK          (CLK),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .pop_req      (pop_req),
    .pop_ack      (pop_ack),
    .drain        (drain),
    .drain_done   (drain_done),
    .fifo_push    (fifo_push),
    .fifo_pop     (fifo_pop),
    .fifo_data_in (fifo_data_in),
    .count        (count),
    .full         (full),
    .empty        (empty),
`ifdef FIFO_ARB_STATS_EN
    .reject_cnt   (reject_cnt),
`endif
    .state_o      (state_o)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] m_exp, m_mask, m_act;
  string        m_name;

  logic [3:0] rr_g[4];
  logic [7:0] rr_d[4];
  logic [3:0] mm_g[5];
  logic [7:0] mm_d[5];

  function automatic logic [W-1:0] mk(input logic [3:0] g, input logic pa, input logic push,
                                      input logic pop, input logic [7:0] d, input logic [3:0] c,
                                      input logic f, input logic e, input logic dd, input logic st);
    return {st, dd, e, f, c, d, pop, push, pa, g};
  endfunction

  // driver
  task automatic drive(input string nm, input logic r, input logic [3:0] rq, input logic pr,
                       input logic dr, input logic [W-1:0] e, input logic [W-1:0] m);
    @(posedge CLK);
    #1;
    rst     = r;
    req     = rq;
    pop_req = pr;
    drain   = dr;
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
  endtask

  // monitor
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_mask = mask_q.pop_front();
      m_name = name_q.pop_front();
      m_act  = {state_o, drain_done, empty, full, count, fifo_data_in,
                fifo_pop, fifo_push, pop_ack, gnt};
      if (m_mask != '0) begin
        n_tests++;
        if ((m_act & m_mask) !== (m_exp & m_mask)) begin
          n_fail++;
          $display("FAIL %s @%0t: got %h expected %h (mask %h)",
                   m_name, $time, m_act & m_mask, m_exp & m_mask, m_mask);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; pop_req = 1'b0; drain = 1'b0;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rr_d = '{8'h11, 8'h22, 8'hA5, 8'h44};
    mm_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    mm_d = '{8'hA5, 8'h44, 8'h11, 8'h22, 8'hA5};

    // reset then idle
    drive("rst1", 1, 4'hF, 1, 0, '0, M_RST1);
    drive("rst2", 1, 4'hF, 1, 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), M_RST2);
    drive("idle", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), M_ALL);

    // round robin fills to full
    for (int k = 0; k < 8; k++)
      drive("rr", 0, 4'hF, 0, 0, mk(rr_g[k%4], 0, 1, 0, rr_d[k%4], 4'(k), 0, (k == 0), 0, 0), M_ALL);
    drive("rr_full", 0, 4'hF, 0, 0, mk(0, 0, 0, 0, 0, 8, 1, 0, 0, 0), M_ALL);

    // full plus pop: no bypass, then push+pop keeps count
    drive("full_pop", 0, 4'b0001, 1, 0, mk(0, 1, 0, 1, 0, 8, 1, 0, 0, 0), M_ALL);
    drive("push_pop", 0, 4'b0001, 1, 0, mk(4'b0001, 1, 1, 1, 8'h11, 7, 0, 0, 0, 0), M_ALL);
    for (int k = 0; k < 7; k++)
      drive("pop_down", 0, 0, 1, 0, mk(0, 1, 0, 1, 0, 4'(7 - k), 0, 0, 0, 0), M_ALL);

    // empty: push with pop_req gives no pass-through
    drive("empty_push", 0, 4'b0100, 1, 0, mk(4'b0100, 0, 1, 0, 8'hA5, 0, 0, 1, 0, 0), M_ALL);
    drive("pop_one", 0, 0, 1, 0, mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0), M_ALL);
    drive("pop_empty", 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), M_ALL);

    // fill to 4, then drain with a same-cycle push (enters DRAIN at 5)
    for (int k = 0; k < 4; k++)
      drive("fill4", 0, 4'b0011, 0, 0, mk(rr_g[k%2], 0, 1, 0, rr_d[k%2], 4'(k), 0, (k == 0), 0, 0), M_ALL);
    drive("drain_go", 0, 4'b0011, 0, 1, mk(4'b0001, 0, 1, 0, 8'h11, 4, 0, 0, 0, 0), M_ALL);
    for (int k = 0; k < 5; k++)
      drive("drain_pop", 0, 4'b0011, 1, (k == 0), mk(0, 0, 0, 1, 0, 4'(5 - k), 0, 0, 0, 1), M_ALL);
    drive("drain_done", 0, 4'b0011, 0, 0, mk(4'b0010, 0, 1, 0, 8'h22, 0, 0, 1, 1, 0), M_ALL);
`ifdef FIFO_ARB_STATS_EN
    #3;
    n_tests++;
    if (reject_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reject_clear: got %0d expected 0", reject_cnt);
    end
`endif
    drive("after_drain", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), M_ALL);

    // fill to 6, drain, reset on the third drain cycle
    for (int k = 0; k < 5; k++)
      drive("fill6", 0, 4'hF, 0, 0, mk(mm_g[k], 0, 1, 0, mm_d[k], 4'(k + 1), 0, 0, 0, 0), M_ALL);
    drive("mid_go", 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 6, 0, 0, 0, 0), M_ALL);
    drive("mid_d1", 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 6, 0, 0, 0, 1), M_ALL);
    drive("mid_d2", 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 5, 0, 0, 0, 1), M_ALL);
    drive("mid_rst", 1, 4'hF, 1, 0, '0, M_RST1);
    drive("post_rst", 0, 4'hF, 0, 0, mk(4'b0001, 0, 1, 0, 8'h11, 0, 0, 1, 0, 0), M_ALL);
    drive("post_rst2", 0, 4'hF, 0, 0, mk(4'b0010, 0, 1, 0, 8'h22, 1, 0, 0, 0, 0), M_ALL);
    drive("end", 0, 0, 0, 0, '0, '0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
